// File: rtl/uart_tx_fifo_cfg.sv
// Buffered UART transmitter: FIFO-fed, configurable data width, runtime parity and stop-bit count.
// Queued words go out back-to-back; each frame snapshots its parity/stop config at pop time.
module uart_tx_fifo_cfg #(
    parameter int CLKS_PER_BIT = 217,
    parameter int DATA_BITS    = 8,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          i_Clock,
    input  logic                          i_Reset,
    input  logic                          i_TX_DV,
    input  logic [DATA_BITS-1:0]          i_TX_Data,
    output logic                          o_TX_Ready,
    input  logic [1:0]                    i_Parity_Mode,
    input  logic                          i_Two_Stop,
    output logic                          o_TX_Active,
    output logic                          o_TX_Serial,
    output logic                          o_TX_Done,
    output logic                          o_Overflow,
    output logic [$clog2(FIFO_DEPTH):0]   o_FIFO_Count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
    localparam logic [AW:0]   DEPTH     = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]        r_wr_ptr, r_rd_ptr;
    logic [AW:0]          r_count, w_count_nxt;
    logic                 r_ready, r_overflow;

    state_t               r_state;
    logic [CW-1:0]        r_baud;
    logic [BW-1:0]        r_bit;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_en, r_par_bit, r_two_stop;
    logic                 r_serial, r_active, r_done;

    logic                 w_push, w_pop, w_bit_end, w_stop_last;
    logic                 w_par_en, w_par_bit;
    logic [DATA_BITS-1:0] w_head;

    assign w_head      = r_mem[r_rd_ptr];
    assign w_push      = i_TX_DV && r_ready;
    assign w_bit_end   = (r_baud == BAUD_LAST);
    assign w_stop_last = (r_state == S_STOP) && w_bit_end && (r_bit == BW'(r_two_stop));
    // Pop from IDLE, or on the final stop cycle so the next start bit follows with no gap.
    assign w_pop       = (r_count != '0) && ((r_state == S_IDLE) || w_stop_last);
    assign w_par_en    = ^i_Parity_Mode;
    assign w_par_bit   = (^w_head) ^ (i_Parity_Mode == 2'b01);

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop)
            w_count_nxt = r_count + (AW+1)'(1);
        else if (!w_push && w_pop)
            w_count_nxt = r_count - (AW+1)'(1);
    end

    always_ff @(posedge i_Clock) begin
        if (w_push)
            r_mem[r_wr_ptr] <= i_TX_Data;
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_ready    <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= i_TX_DV && !r_ready;
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count    <= w_count_nxt;
            r_ready    <= (w_count_nxt < DEPTH);
        end
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_state    <= S_IDLE;
            r_baud     <= '0;
            r_bit      <= '0;
            r_shift    <= '0;
            r_par_en   <= 1'b0;
            r_par_bit  <= 1'b0;
            r_two_stop <= 1'b0;
            r_serial   <= 1'b1;
            r_active   <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_pop) begin
                r_shift    <= w_head;
                r_par_en   <= w_par_en;
                r_par_bit  <= w_par_bit;
                r_two_stop <= i_Two_Stop;
            end
            case (r_state)
                S_IDLE: begin
                    r_serial <= 1'b1;
                    r_active <= 1'b0;
                    r_baud   <= '0;
                    if (w_pop) begin
                        r_state  <= S_START;
                        r_serial <= 1'b0;
                        r_active <= 1'b1;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_baud   <= '0;
                        r_bit    <= '0;
                        r_state  <= S_DATA;
                        r_serial <= r_shift[0];
                    end else
                        r_baud <= r_baud + CW'(1);
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_baud <= '0;
                        if (r_bit == BIT_LAST) begin
                            r_bit    <= '0;
                            r_state  <= r_par_en ? S_PARITY : S_STOP;
                            r_serial <= r_par_en ? r_par_bit : 1'b1;
                        end else begin
                            r_bit    <= r_bit + BW'(1);
                            r_shift  <= r_shift >> 1;
                            r_serial <= r_shift[1];
                        end
                    end else
                        r_baud <= r_baud + CW'(1);
                end
                S_PARITY: begin
                    if (w_bit_end) begin
                        r_baud   <= '0;
                        r_bit    <= '0;
                        r_state  <= S_STOP;
                        r_serial <= 1'b1;
                    end else
                        r_baud <= r_baud + CW'(1);
                end
                S_STOP: begin
                    if (w_bit_end) begin
                        r_baud <= '0;
                        if (w_stop_last) begin
                            r_done <= 1'b1;
                            r_bit  <= '0;
                            if (w_pop) begin
                                r_state  <= S_START;
                                r_serial <= 1'b0;
                            end else begin
                                r_state  <= S_IDLE;
                                r_active <= 1'b0;
                            end
                        end else
                            r_bit <= r_bit + BW'(1);
                    end else
                        r_baud <= r_baud + CW'(1);
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_TX_Ready   = r_ready;
    assign o_Overflow   = r_overflow;
    assign o_FIFO_Count = r_count;
    assign o_TX_Serial  = r_serial;
    assign o_TX_Active  = r_active;
    assign o_TX_Done    = r_done;
endmodule

// File: tb/tb_uart_tx_fifo_cfg.sv
// Directed bench for uart_tx_fifo_cfg: 8-bit and 5-bit instances at 4 clocks per bit.
module tb_uart_tx_fifo_cfg;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       dv8, two8, rdy8, act8, ser8, done8, ovf8;
    logic [7:0] data8;
    logic [1:0] pm8;
    logic [2:0] cnt8;
    logic       dv5, two5, rdy5, act5, ser5, done5, ovf5;
    logic [4:0] data5;
    logic [1:0] pm5;
    logic [2:0] cnt5;

    int n_cmp = 0;
    int n_bad = 0;

    uart_tx_fifo_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(8), .FIFO_DEPTH(4)) u8 (
        .i_Clock(clk), .i_Reset(rst), .i_TX_DV(dv8), .i_TX_Data(data8), .o_TX_Ready(rdy8),
        .i_Parity_Mode(pm8), .i_Two_Stop(two8), .o_TX_Active(act8), .o_TX_Serial(ser8),
        .o_TX_Done(done8), .o_Overflow(ovf8), .o_FIFO_Count(cnt8));

    uart_tx_fifo_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(5), .FIFO_DEPTH(4)) u5 (
        .i_Clock(clk), .i_Reset(rst), .i_TX_DV(dv5), .i_TX_Data(data5), .o_TX_Ready(rdy5),
        .i_Parity_Mode(pm5), .i_Two_Stop(two5), .o_TX_Active(act5), .o_TX_Serial(ser5),
        .o_TX_Done(done5), .o_Overflow(ovf5), .o_FIFO_Count(cnt5));

    task automatic push8(input logic [7:0] d);
        @(posedge clk); #1 dv8 = 1'b1; data8 = d;
        @(posedge clk); #1 dv8 = 1'b0;
    endtask

    task automatic push5(input logic [4:0] d);
        @(posedge clk); #1 dv5 = 1'b1; data5 = d;
        @(posedge clk); #1 dv5 = 1'b0;
    endtask

    // Waits for the start bit, then records one frame plus two trailing cycles.
    task automatic capture(input bit sel, input int nbits, output bit found,
                           output logic [15:0] bits, output bit stable, output int ndone,
                           output bit done_end, output bit act_ok);
        logic s [0:79];
        logic a [0:79];
        logic d [0:79];
        int len;
        len = nbits * 4;
        found = 0; bits = '0; stable = 1; ndone = 0; done_end = 0; act_ok = 0;
        for (int t = 0; t < 30; t++) begin
            @(negedge clk);
            if ((sel ? ser5 : ser8) === 1'b0) begin found = 1; break; end
        end
        if (!found) return;
        for (int k = 0; k <= len + 1; k++) begin
            if (k > 0) @(negedge clk);
            s[k] = sel ? ser5 : ser8;
            a[k] = sel ? act5 : act8;
            d[k] = sel ? done5 : done8;
        end
        for (int i = 0; i < nbits; i++) begin
            bits[i] = s[4*i+2];
            for (int j = 0; j < 4; j++)
                if (s[4*i+j] !== s[4*i+2]) stable = 0;
        end
        for (int k = 0; k <= len + 1; k++)
            if (d[k] === 1'b1) ndone++;
        done_end = (d[len] === 1'b1);
        act_ok = (a[len] === 1'b0);
        for (int k = 0; k < len; k++)
            if (a[k] !== 1'b1) act_ok = 0;
    endtask

    task automatic test_reset;
        #2;
        n_cmp++; if (ser8 !== 1'b1)  begin n_bad++; $display("FAIL reset_serial: got %b want 1", ser8); end
        n_cmp++; if (act8 !== 1'b0)  begin n_bad++; $display("FAIL reset_active: got %b want 0", act8); end
        n_cmp++; if (done8 !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done8); end
        n_cmp++; if (ovf8 !== 1'b0)  begin n_bad++; $display("FAIL reset_overflow: got %b want 0", ovf8); end
        n_cmp++; if (rdy8 !== 1'b1)  begin n_bad++; $display("FAIL reset_ready: got %b want 1", rdy8); end
        n_cmp++; if (cnt8 !== 3'd0)  begin n_bad++; $display("FAIL reset_count: got %0d want 0", cnt8); end
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic test_frame_basic;
        bit f, st, de, ao; logic [15:0] b; int nd;
        pm8 = 2'b00; two8 = 1'b0;
        push8(8'h3F);
        capture(0, 10, f, b, st, nd, de, ao);
        n_cmp++; if (!f) begin n_bad++; $display("FAIL basic_start: no start bit got 0 want 1"); end
        n_cmp++; if ({st, b[9:0]} !== {1'b1, 10'b1001111110})
            begin n_bad++; $display("FAIL basic_line: got %b/%b want 1/1001111110", st, b[9:0]); end
        n_cmp++; if (b[8:1] !== 8'h3F) begin n_bad++; $display("FAIL basic_rx: got %h want 3f", b[8:1]); end
        n_cmp++; if (nd !== 1 || !de) begin n_bad++; $display("FAIL basic_done: got n=%0d at40=%b want 1/1", nd, de); end
        n_cmp++; if (!ao) begin n_bad++; $display("FAIL basic_active: got 0 want 1"); end
    endtask

    task automatic test_parity;
        bit f, st, de, ao; logic [15:0] b; int nd;
        pm8 = 2'b10; two8 = 1'b0;
        push8(8'h3F);
        capture(0, 11, f, b, st, nd, de, ao);
        n_cmp++; if ({f, st, b[10:0]} !== {2'b11, 11'b10001111110})
            begin n_bad++; $display("FAIL even_line: got %b%b/%b want 11/10001111110", f, st, b[10:0]); end
        n_cmp++; if (nd !== 1 || !de || !ao)
            begin n_bad++; $display("FAIL even_len44: got n=%0d end=%b act=%b want 1/1/1", nd, de, ao); end
        repeat (3) @(posedge clk);
        pm8 = 2'b01;
        push8(8'h3F);
        capture(0, 11, f, b, st, nd, de, ao);
        n_cmp++; if ({f, st, b[10:0]} !== {2'b11, 11'b11001111110})
            begin n_bad++; $display("FAIL odd_line: got %b%b/%b want 11/11001111110", f, st, b[10:0]); end
        n_cmp++; if (nd !== 1 || !de || !ao)
            begin n_bad++; $display("FAIL odd_len44: got n=%0d end=%b act=%b want 1/1/1", nd, de, ao); end
        repeat (3) @(posedge clk);
        pm8 = 2'b10; two8 = 1'b1;
        push8(8'h3F);
        capture(0, 12, f, b, st, nd, de, ao);
        n_cmp++; if ({f, st, b[11:0]} !== {2'b11, 12'b110001111110})
            begin n_bad++; $display("FAIL two_stop_line: got %b%b/%b want 11/110001111110", f, st, b[11:0]); end
        n_cmp++; if (nd !== 1 || !de || !ao)
            begin n_bad++; $display("FAIL two_stop_len48: got n=%0d end=%b act=%b want 1/1/1", nd, de, ao); end
        two8 = 1'b0; pm8 = 2'b00;
        repeat (3) @(posedge clk);
    endtask

    task automatic test_back_to_back;
        logic [7:0] wv [0:5];
        logic [7:0] exp_w [0:4];
        logic s [0:219];
        logic a [0:219];
        logic d [0:219];
        logic o [0:219];
        logic [2:0] c [0:219];
        logic r [0:219];
        logic [7:0] rx;
        int nd, no, bad_act, bad_done, bad_idle;
        wv = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hFF};
        exp_w = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5};
        for (int cyc = 0; cyc < 210; cyc++) begin
            @(posedge clk); #1;
            if (cyc < 6) begin dv8 = 1'b1; data8 = wv[cyc]; end else dv8 = 1'b0;
            @(negedge clk);
            s[cyc] = ser8; a[cyc] = act8; d[cyc] = done8; o[cyc] = ovf8; c[cyc] = cnt8; r[cyc] = rdy8;
        end
        n_cmp++; if (c[5] !== 3'd4 || r[5] !== 1'b0)
            begin n_bad++; $display("FAIL burst_peak: got cnt=%0d rdy=%b want 4/0", c[5], r[5]); end
        n_cmp++; if (s[2] !== 1'b0 || a[1] !== 1'b0)
            begin n_bad++; $display("FAIL burst_first_start: got ser=%b act_before=%b want 0/0", s[2], a[1]); end
        no = 0;
        for (int k = 0; k < 210; k++) if (o[k] === 1'b1) no++;
        n_cmp++; if (o[6] !== 1'b1 || no !== 1)
            begin n_bad++; $display("FAIL overflow_pulse: got at6=%b n=%0d want 1/1", o[6], no); end
        n_cmp++; if (c[6] !== 3'd4) begin n_bad++; $display("FAIL overflow_count: got %0d want 4", c[6]); end
        bad_act = 0;
        for (int k = 2; k < 202; k++) if (a[k] !== 1'b1) bad_act++;
        n_cmp++; if (bad_act !== 0 || a[202] !== 1'b0)
            begin n_bad++; $display("FAIL burst_active: got gaps=%0d end=%b want 0/0", bad_act, a[202]); end
        nd = 0; bad_done = 0;
        for (int k = 0; k < 210; k++) if (d[k] === 1'b1) nd++;
        for (int f = 0; f < 5; f++) if (d[42+40*f] !== 1'b1) bad_done++;
        n_cmp++; if (nd !== 5 || bad_done !== 0)
            begin n_bad++; $display("FAIL burst_done: got n=%0d misplaced=%0d want 5/0", nd, bad_done); end
        for (int f = 0; f < 5; f++) begin
            for (int i = 0; i < 8; i++) rx[i] = s[8 + 40*f + 4*i];
            n_cmp++; if (rx !== exp_w[f])
                begin n_bad++; $display("FAIL burst_word%0d: got %h want %h", f, rx, exp_w[f]); end
        end
        bad_idle = 0;
        for (int k = 202; k < 210; k++) if (s[k] !== 1'b1) bad_idle++;
        n_cmp++; if (bad_idle !== 0) begin n_bad++; $display("FAIL no_ff_frame: got low=%0d want 0", bad_idle); end
    endtask

    task automatic test_reset_mid;
        logic [7:0] wv [0:3];
        int nd, nlow;
        bit f, st, de, ao; logic [15:0] b;
        wv = '{8'h11, 8'h22, 8'h33, 8'h44};
        pm8 = 2'b00; two8 = 1'b0;
        for (int cyc = 0; cyc < 16; cyc++) begin
            @(posedge clk); #1;
            if (cyc < 4) begin dv8 = 1'b1; data8 = wv[cyc]; end else dv8 = 1'b0;
            @(negedge clk);
        end
        n_cmp++; if (cnt8 !== 3'd3 || act8 !== 1'b1)
            begin n_bad++; $display("FAIL pre_reset: got cnt=%0d act=%b want 3/1", cnt8, act8); end
        #1 rst = 1'b1;
        #1;
        n_cmp++; if (ser8 !== 1'b1 || act8 !== 1'b0)
            begin n_bad++; $display("FAIL midreset_line: got ser=%b act=%b want 1/0", ser8, act8); end
        n_cmp++; if (cnt8 !== 3'd0 || rdy8 !== 1'b1)
            begin n_bad++; $display("FAIL midreset_fifo: got cnt=%0d rdy=%b want 0/1", cnt8, rdy8); end
        @(posedge clk); #1 rst = 1'b0;
        nd = 0; nlow = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (done8 === 1'b1) nd++;
            if (ser8 !== 1'b1) nlow++;
        end
        n_cmp++; if (nd !== 0 || nlow !== 0 || cnt8 !== 3'd0)
            begin n_bad++; $display("FAIL post_reset_quiet: got done=%0d low=%0d cnt=%0d want 0/0/0", nd, nlow, cnt8); end
        push8(8'h5A);
        capture(0, 10, f, b, st, nd, de, ao);
        n_cmp++; if ({f, st, b[9:0]} !== {2'b11, 1'b1, 8'h5A, 1'b0})
            begin n_bad++; $display("FAIL post_reset_frame: got %b%b/%b want 11/1010110100", f, st, b[9:0]); end
        n_cmp++; if (nd !== 1 || !de || !ao)
            begin n_bad++; $display("FAIL post_reset_done: got n=%0d end=%b act=%b want 1/1/1", nd, de, ao); end
    endtask

    task automatic test_5bit;
        bit f, st, de, ao; logic [15:0] b; int nd;
        pm5 = 2'b01; two5 = 1'b0;
        push5(5'h15);
        capture(1, 8, f, b, st, nd, de, ao);
        n_cmp++; if ({f, st, b[7:0]} !== {2'b11, 8'b10101010})
            begin n_bad++; $display("FAIL w5_line: got %b%b/%b want 11/10101010", f, st, b[7:0]); end
        n_cmp++; if (b[5:1] !== 5'h15) begin n_bad++; $display("FAIL w5_rx: got %h want 15", b[5:1]); end
        n_cmp++; if (nd !== 1 || !de || !ao)
            begin n_bad++; $display("FAIL w5_len32: got n=%0d end=%b act=%b want 1/1/1", nd, de, ao); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, compared %0d mismatched %0d", n_cmp, n_bad);
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        dv8 = 1'b0; data8 = '0; pm8 = 2'b00; two8 = 1'b0;
        dv5 = 1'b0; data5 = '0; pm5 = 2'b00; two5 = 1'b0;
        test_reset;
        repeat (2) @(posedge clk);
        test_frame_basic;
        repeat (3) @(posedge clk);
        test_parity;
        test_back_to_back;
        repeat (3) @(posedge clk);
        test_reset_mid;
        repeat (3) @(posedge clk);
        test_5bit;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/uart_tx_fifo_cfg.md
Name: uart_tx_fifo_cfg

Overview:
Parametrised, buffered UART transmitter; the next generation of the single-byte 8N1 TX. It generalises data width and adds runtime-selectable parity and stop-bit count. A FIFO lets the host queue several words, which are sent back-to-back with no idle gap. It sits between the host/bus logic and the serial pin, and drives the same line as the existing UART RX under loopback.

Parameters:
CLKS_PER_BIT, 217, clock cycles per serial bit (≥2); 25 MHz / 115200 baud.
DATA_BITS, 8, data bits per frame, legal range 5..9.
FIFO_DEPTH, 4, words of buffering; power of 2, ≥2.

Ports:
i_Clock  in  1  system clock
i_Reset  in  1  asynchronous active-high reset
i_TX_DV  in  1  write strobe; accepted when o_TX_Ready=1
i_TX_Data  in  DATA_BITS  word to queue
o_TX_Ready  out  1  FIFO not full
i_Parity_Mode  in  2  00 none, 01 odd, 10 even, 11 none
i_Two_Stop  in  1  1 = two stop bits, 0 = one
o_TX_Active  out  1  high while any frame bit (start..last stop) is on the line
o_TX_Serial  out  1  serial line, idle high
o_TX_Done  out  1  one-cycle pulse at end of each frame's last stop bit
o_Overflow  out  1  one-cycle pulse when i_TX_DV=1 while FIFO full
o_FIFO_Count  out  $clog2(FIFO_DEPTH)+1  words queued, not including the word in flight

Behaviour:
- Reset (async, any state, incl. mid-frame):
  - o_TX_Serial=1, o_TX_Active=0, o_TX_Done=0, o_Overflow=0, o_TX_Ready=1, o_FIFO_Count=0.
  - FIFO emptied; FSM to IDLE. The partial frame is abandoned, and the line goes high immediately.
- FIFO:
  - Push when i_TX_DV && o_TX_Ready.
  - o_TX_Ready = (count < FIFO_DEPTH), driven from registered count.
  - Push while full is dropped and pulses o_Overflow, even if a pop occurs the same cycle.
  - Simultaneous push and pop when not full: count unchanged, data order preserved.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: line high. If FIFO non-empty, pop the head, latch the word and snapshot i_Parity_Mode/i_Two_Stop, then go to START next cycle. Latency from first push into an empty FIFO to the start bit on the line is 2 cycles.
  - START: drive 0 for CLKS_PER_BIT cycles. o_TX_Active goes high on the first START cycle.
  - DATA: DATA_BITS bits, LSB first, CLKS_PER_BIT cycles each. Then go to PARITY if mode is 01/10, else STOP.
  - PARITY: odd mode makes total ones (data + parity) odd; even mode makes it even. Computed on the latched word. Lasts CLKS_PER_BIT cycles.
  - STOP: drive 1 for CLKS_PER_BIT cycles (×2 if the snapshot i_Two_Stop=1).
- End of STOP (last cycle):
  - o_TX_Done pulses for 1 cycle.
  - If FIFO non-empty: pop in that same cycle and enter START on the next cycle. o_TX_Active stays high, with no idle gap.
  - Otherwise go to IDLE; o_TX_Active drops the cycle after.
- Configuration changes mid-frame have no effect until the next frame.
- Frame length in cycles = CLKS_PER_BIT × (1 + DATA_BITS + P + S), where P ∈ {0,1} and S ∈ {1,2}.
- A single bit counter (width ≥ $clog2(DATA_BITS)) and a baud counter (width $clog2(CLKS_PER_BIT)) are used; the baud counter resets on each bit boundary.
- All outputs are registered; there are no combinational paths from inputs to o_TX_Serial.

Test Plan:
1. CLKS_PER_BIT=4, DATA_BITS=8, mode 00, i_Two_Stop=0; push 8'h3F:
   - Line shows 0,1,1,1,1,1,1,0,0,1, each bit 4 cycles.
   - o_TX_Done pulses once, 40 cycles after the start-bit edge.
   - Loopback RX returns 8'h3F.
2. Same word 8'h3F, mode 10 (even), then mode 01 (odd):
   - Parity bit 0 for even, then 1 for odd.
   - Frames are 44 cycles.
   - With i_Two_Stop=1 the frame is 48 cycles, with the stop level held 8 cycles.
3. FIFO_DEPTH=4; push 8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5 on consecutive cycles while idle:
   - First word popped immediately, so all 5 are accepted (o_FIFO_Count peaks at 4).
   - Frames are back-to-back with o_TX_Active continuously high.
   - 5 o_TX_Done pulses, data in order.
4. With the FIFO full (count=4 during the first frame), assert i_TX_DV with 8'hFF:
   - o_Overflow pulses once.
   - count stays 4; 8'hFF is never transmitted.
5. Assert i_Reset mid-DATA of the first frame with 3 words queued:
   - o_TX_Serial=1 and o_TX_Active=0 within the same cycle (async).
   - count=0; no o_TX_Done pulse.
   - The next push transmits normally.
6. DATA_BITS=5, mode 01; push 5'h15:
   - Line shows 0,1,0,1,0,1, then parity 0 (three ones already odd), then stop 1.
   - Frame is 8×CLKS_PER_BIT cycles.
